// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: channel states, button indices, pulse arbitration.
// Pure declarations; no latency and no flow control.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_RELEASED,
        ST_HELD_DELAY,
        ST_HELD_REPEAT
    } chan_state_t;

    localparam int NUM_BTN    = 5;
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Priority: center > up > down > left > right. Losers are dropped, not queued.
    function automatic logic [NUM_BTN-1:0] arbitrate(input logic [NUM_BTN-1:0] req);
        logic [NUM_BTN-1:0] grant;
        grant = '0;
        if (req[BTN_CENTER])     grant[BTN_CENTER] = 1'b1;
        else if (req[BTN_UP])    grant[BTN_UP]     = 1'b1;
        else if (req[BTN_DOWN])  grant[BTN_DOWN]   = 1'b1;
        else if (req[BTN_LEFT])  grant[BTN_LEFT]   = 1'b1;
        else if (req[BTN_RIGHT]) grant[BTN_RIGHT]  = 1'b1;
        return grant;
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button: 2-FF sync, counter debounce, press/auto-repeat FSM producing a registered request.
// Request appears DEBOUNCE_CYCLES+2 edges after the first raw-high sample; no backpressure.
module button_conditioner_channel
    import button_conditioner_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter int   REPEAT_DELAY    = 50_000_000,
    parameter int   REPEAT_PERIOD   = 20_000_000,
    parameter logic REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_raw,
    output logic o_req
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [DB_W-1:0] DB_TERM     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_TERM  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_TERM = RP_W'(REPEAT_PERIOD - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [DB_W-1:0] r_db_cnt;
    logic [RP_W-1:0] r_rpt_cnt;
    logic            r_req;
    chan_state_t     r_state;

    chan_state_t     w_state_nxt;
    logic [RP_W-1:0] w_rpt_nxt;
    logic            w_req_nxt;

    // Level powers up high so a button held through reset cannot fire.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b1;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_TERM) begin
                r_level  <= ~r_level;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state   <= ST_LOCKED;
            r_rpt_cnt <= '0;
            r_req     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_nxt;
            r_req     <= w_req_nxt;
        end
    end

    // Release wins over a coincident repeat terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_rpt_nxt   = r_rpt_cnt;
        w_req_nxt   = 1'b0;
        case (r_state)
            ST_LOCKED: begin
                if (!r_level) w_state_nxt = ST_RELEASED;
            end
            ST_RELEASED: begin
                if (r_level) begin
                    w_state_nxt = ST_HELD_DELAY;
                    w_rpt_nxt   = '0;
                    w_req_nxt   = 1'b1;
                end
            end
            ST_HELD_DELAY: begin
                if (!r_level) begin
                    w_state_nxt = ST_RELEASED;
                    w_rpt_nxt   = '0;
                end else if (r_rpt_cnt == DELAY_TERM) begin
                    if (REPEAT_EN) begin
                        w_state_nxt = ST_HELD_REPEAT;
                        w_rpt_nxt   = '0;
                        w_req_nxt   = 1'b1;
                    end
                end else begin
                    w_rpt_nxt = r_rpt_cnt + 1'b1;
                end
            end
            ST_HELD_REPEAT: begin
                if (!r_level) begin
                    w_state_nxt = ST_RELEASED;
                    w_rpt_nxt   = '0;
                end else if (r_rpt_cnt == PERIOD_TERM) begin
                    w_rpt_nxt = '0;
                    w_req_nxt = 1'b1;
                end else begin
                    w_rpt_nxt = r_rpt_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_LOCKED;
                w_rpt_nxt   = '0;
            end
        endcase
    end

    assign o_req = r_req;

endmodule

// File: rtl/button_conditioner.sv
// Five debounced push-button channels with one registered, priority-arbitrated pulse per cycle.
// Press pulse DEBOUNCE_CYCLES+3 edges after first raw-high sample; no backpressure, losers dropped.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int             DEBOUNCE_CYCLES = 1_000_000,
    parameter int             REPEAT_DELAY    = 50_000_000,
    parameter int             REPEAT_PERIOD   = 20_000_000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK = 5'b01111
) (
    input  logic clk,
    input  logic resetN,
    input  logic upButton,
    input  logic downButton,
    input  logic leftButton,
    input  logic rightButton,
    input  logic centerButton,
    output logic upPulse,
    output logic downPulse,
    output logic leftPulse,
    output logic rightPulse,
    output logic centerPulse
);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_req;
    logic [NUM_BTN-1:0] r_pulse;

    assign w_raw[BTN_UP]     = upButton;
    assign w_raw[BTN_DOWN]   = downButton;
    assign w_raw[BTN_LEFT]   = leftButton;
    assign w_raw[BTN_RIGHT]  = rightButton;
    assign w_raw[BTN_CENTER] = centerButton;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        button_conditioner_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[g])
        ) u_chan (
            .clk    (clk),
            .resetN (resetN),
            .i_raw  (w_raw[g]),
            .o_req  (w_req[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!resetN) r_pulse <= '0;
        else         r_pulse <= arbitrate(w_req);
    end

    assign upPulse     = r_pulse[BTN_UP];
    assign downPulse   = r_pulse[BTN_DOWN];
    assign leftPulse   = r_pulse[BTN_LEFT];
    assign rightPulse  = r_pulse[BTN_RIGHT];
    assign centerPulse = r_pulse[BTN_CENTER];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
// Pulse vectors are compared every cycle against hand-computed expected edges.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic upButton = 1'b0, downButton = 1'b0, leftButton = 1'b0;
    logic rightButton = 1'b0, centerButton = 1'b0;
    logic upPulse, downPulse, leftPulse, rightPulse, centerPulse;

    int n_checks = 0;
    int n_errors = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5),
        .REPEAT_MASK     (5'b01111)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .upButton     (upButton),
        .downButton   (downButton),
        .leftButton   (leftButton),
        .rightButton  (rightButton),
        .centerButton (centerButton),
        .upPulse      (upPulse),
        .downPulse    (downPulse),
        .leftPulse    (leftPulse),
        .rightPulse   (rightPulse),
        .centerPulse  (centerPulse)
    );

    always #5 clk = ~clk;

    // Bit order {center,right,left,down,up}.
    function automatic logic [4:0] pulses();
        return {centerPulse, rightPulse, leftPulse, downPulse, upPulse};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: pulses=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive_raw(input logic [4:0] v);
        upButton     = v[0];
        downButton   = v[1];
        leftButton   = v[2];
        rightButton  = v[3];
        centerButton = v[4];
    endtask

    // Step k: raw drives edge k, outputs checked 1 ns after edge k.
    // Steps below bounce_n alternate 1/0; then raw is steady until hold_n.
    task automatic run_win(input string tag, input logic [4:0] btns, input int bounce_n,
                           input int hold_n, input int total_n, input int rst_at,
                           input logic [63:0] exp_mask, input logic [4:0] chan);
        for (int k = 0; k < total_n; k++) begin
            logic lvl;
            if (k < bounce_n) lvl = ((k % 2) == 0);
            else              lvl = (k < hold_n);
            drive_raw(lvl ? btns : 5'b00000);
            resetN = (k == rst_at) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("%s@%0d", tag, k), pulses(), exp_mask[6'(k)] ? chan : 5'b00000);
        end
        resetN = 1'b1;
    endtask

    localparam logic [63:0] AT7  = 64'd1 << 7;
    localparam logic [63:0] AT11 = 64'd1 << 11;
    localparam logic [63:0] LEFT_RPT = (64'd1 << 7) | (64'd1 << 17) | (64'd1 << 22) |
                                       (64'd1 << 27) | (64'd1 << 32) | (64'd1 << 37) |
                                       (64'd1 << 42);
    localparam logic [63:0] LEFT_RST = (64'd1 << 7) | (64'd1 << 17) | (64'd1 << 22);

    initial begin
        resetN = 1'b0;
        drive_raw(5'b00000);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset", pulses(), 5'b00000);
        end

        run_win("idle",       5'b00000, 0, 0,  12, -1, 64'd0,    5'b00000);
        run_win("up_clean",   5'b00001, 0, 10, 24, -1, AT7,      5'b00001);
        run_win("up_bounce",  5'b00001, 4, 14, 30, -1, AT11,     5'b00001);
        run_win("left_rpt",   5'b00100, 0, 40, 64, -1, LEFT_RPT, 5'b00100);
        run_win("center",     5'b10000, 0, 40, 56, -1, AT7,      5'b10000);
        run_win("up_right",   5'b01001, 0, 8,  20, -1, AT7,      5'b00001);
        run_win("right_only", 5'b01000, 0, 8,  20, -1, AT7,      5'b01000);

        drive_raw(5'b00010);
        resetN = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_down", pulses(), 5'b00000);
        end
        run_win("down_locked", 5'b00010, 0, 30, 30, -1, 64'd0, 5'b00000);
        run_win("down_rel",    5'b00000, 0, 0,  12, -1, 64'd0, 5'b00000);
        run_win("down_press",  5'b00010, 0, 8,  20, -1, AT7,   5'b00010);

        run_win("left_rst",   5'b00100, 0, 50, 64, 27, LEFT_RST, 5'b00100);
        run_win("left_fresh", 5'b00100, 0, 8,  20, -1, AT7,      5'b00100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
